irq_controller: RTL and testbench

Parametrised, memory-mapped vectored interrupt controller for the tinySoC CPU. It replaces the three fixed `interrupt_0..2` lines with up to eight prioritised channels. Each channel is individually enabled and can be configured for edge or level triggering. The block supports preemptive nesting through an in-service register. It sits on the data-memory/IO bus and drives the control unit's interrupt request and vector inputs.

---
 rtl/irq_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_irq_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Purpose : memory-mapped vectored interrupt controller, up to 8 prioritised
//           channels (0 = highest), edge/level per channel, preemptive nesting.
// Latency : pin rise -> irq_req high 4 cycles later; bus read data 1 cycle after bus_re.
// Backpr. : irq_req/irq_vector hold until irq_ack or until the channel stops
//           being the candidate, which withdraws the request with no ack.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   irq_in[N_IRQ]       raw asynchronous interrupt sources, active-high
//   bus_addr/wdata      IO bus address and write data
//   bus_we / bus_re     one-cycle write / read strobes
//   bus_rdata           registered read data, 0 unless the previous cycle was a read hit
//   irq_req             interrupt request to the control unit
//   irq_vector          vector of the requesting channel, stable while irq_req is high
//   irq_ack             one-cycle pulse when the control unit takes the vector
//   irq_active          at least one in-service bit is set
//
// Register window (offset from BASE_ADDR)
//   0 IE (RW)   1 PEND (R, W1C on edge channels)   2 MODE (RW, 1 = edge)
//   3 ISR (RO)  4 EOI (WO)   5 SWI (WO, W1S on edge channels)   6-7 reserved

module irq_controller #(
    parameter int          N_IRQ      = 8,
    parameter logic [15:0] BASE_ADDR  = 16'h1080,
    parameter logic [15:0] VEC_BASE   = 16'h0002,
    parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [15:0]      bus_addr,
    input  logic [7:0]       bus_wdata,
    input  logic             bus_we,
    input  logic             bus_re,
    output logic [7:0]       bus_rdata,
    output logic             irq_req,
    output logic [15:0]      irq_vector,
    input  logic             irq_ack,
    output logic             irq_active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0]       OFF_IE   = 3'd0;
    localparam logic [2:0]       OFF_PEND = 3'd1;
    localparam logic [2:0]       OFF_MODE = 3'd2;
    localparam logic [2:0]       OFF_ISR  = 3'd3;
    localparam logic [2:0]       OFF_EOI  = 3'd4;
    localparam logic [2:0]       OFF_SWI  = 3'd5;
    localparam logic [N_IRQ-1:0] ONE      = 1;

    // ------------------------------------------------------------------
    // Input synchronisers plus a delay stage for rising-edge detection
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] sync1_q, sync2_q, dly_q;
    logic [N_IRQ-1:0] rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise = sync2_q & ~dly_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [15:0] offset;
    logic        hit;
    logic [2:0]  sel;
    logic        wr_ie, wr_pend, wr_mode, wr_eoi, wr_swi;

    assign offset  = bus_addr - BASE_ADDR;
    assign hit     = (offset[15:3] == 13'd0);
    assign sel     = offset[2:0];
    assign wr_ie   = bus_we && hit && (sel == OFF_IE);
    assign wr_pend = bus_we && hit && (sel == OFF_PEND);
    assign wr_mode = bus_we && hit && (sel == OFF_MODE);
    assign wr_eoi  = bus_we && hit && (sel == OFF_EOI);
    assign wr_swi  = bus_we && hit && (sel == OFF_SWI);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] ie_q, ie_d;
    logic [N_IRQ-1:0] mode_q, mode_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [7:0]       rdata_q, rdata_d;
    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      vec_q, vec_d;

    // ------------------------------------------------------------------
    // Candidate selection: lowest-index pending+enabled channel whose index
    // is strictly below the lowest in-service index.
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] allowed;
    logic [N_IRQ-1:0] cand_vec;
    logic             cand_any;
    logic [2:0]       cand_idx;
    logic             blocked;

    always_comb begin
        allowed = '0;
        blocked = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            // Once an ISR bit is seen, it and everything above it is masked.
            blocked    = blocked | isr_q[i];
            allowed[i] = ~blocked;
        end
    end

    assign cand_vec = pend_q & ie_q & allowed;

    always_comb begin
        cand_any = 1'b0;
        cand_idx = 3'd0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (cand_vec[i] && !cand_any) begin
                cand_any = 1'b1;
                cand_idx = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    logic             ack_take;
    logic [N_IRQ-1:0] ack_mask;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_any) begin
                    idx_d   = cand_idx;
                    vec_d   = VEC_BASE + VEC_STRIDE * {13'd0, cand_idx};
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_HOLD;
                end else if (!(cand_any && (cand_idx == idx_q))) begin
                    // Latched channel lost its claim: withdraw without an ack.
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_mask[i] = ack_take && (idx_q == 3'(i));
        end
    end

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    always_comb begin
        ie_d   = wr_ie   ? bus_wdata[N_IRQ-1:0] : ie_q;
        mode_d = wr_mode ? bus_wdata[N_IRQ-1:0] : mode_q;
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (mode_q[i]) begin
                // Edge: sticky; a set in the same cycle as a clear wins.
                pend_d[i] = rise[i] | (wr_swi & bus_wdata[i])
                          | (pend_q[i] & ~((wr_pend & bus_wdata[i]) | ack_mask[i]));
            end else begin
                // Level: tracks the synchronised pin, never latched.
                pend_d[i] = sync2_q[i];
            end
        end
    end

    always_comb begin
        isr_d = isr_q;
        // EOI works on the pre-ack ISR so the bit being acked is never retired.
        if (wr_eoi) begin
            isr_d = isr_q & (isr_q - ONE);
        end
        isr_d = isr_d | ack_mask;
    end

    always_comb begin
        logic [7:0] rd_val;
        rd_val = 8'h00;
        case (sel)
            OFF_IE:   rd_val[N_IRQ-1:0] = ie_q;
            OFF_PEND: rd_val[N_IRQ-1:0] = pend_q;
            OFF_MODE: rd_val[N_IRQ-1:0] = mode_q;
            OFF_ISR:  rd_val[N_IRQ-1:0] = isr_q;
            default:  rd_val = 8'h00;
        endcase
        rdata_d = (bus_re && hit) ? rd_val : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q    <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            rdata_q <= 8'h00;
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            vec_q   <= 16'h0000;
        end else begin
            ie_q    <= ie_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq_req    = (state_q == ST_REQ);
    assign irq_vector = vec_q;
    assign irq_active = |isr_q;
    assign bus_rdata  = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [15:0] A_IE   = 16'h1080;
    localparam logic [15:0] A_PEND = 16'h1081;
    localparam logic [15:0] A_MODE = 16'h1082;
    localparam logic [15:0] A_ISR  = 16'h1083;
    localparam logic [15:0] A_EOI  = 16'h1084;
    localparam logic [15:0] A_SWI  = 16'h1085;
    localparam logic [15:0] A_RSV6 = 16'h1086;
    localparam logic [15:0] A_OUT  = 16'h1088;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack;
    logic        irq_active;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;
    bit ok;

    irq_controller #(
        .N_IRQ(8), .BASE_ADDR(16'h1080), .VEC_BASE(16'h0002), .VEC_STRIDE(16'h0002)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .irq_req(irq_req), .irq_vector(irq_vector),
        .irq_ack(irq_ack), .irq_active(irq_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // All stimulus is applied and all outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_re   = 1'b1;
        tick();
        bus_re   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic pulse_irq(input int ch);
        irq_in[ch] = 1'b1;
        tick();
        irq_in[ch] = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_req(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i <= max && !found; i++) begin
            if (irq_req === 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", irq_req); end
        checks++; if (irq_vector !== 16'h0000) begin errors++; $display("FAIL rst_vector: got %h expected 0000", irq_vector); end
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", bus_rdata); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", irq_active); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_read(A_IE, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ie: got %h expected 00", rd); end
        bus_read(A_MODE, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_mode: got %h expected 00", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_pend: got %h expected 00", rd); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_isr: got %h expected 00", rd); end
        tick();
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rdata_idle: got %h expected 00", bus_rdata); end
    endtask

    task automatic test_edge_single();
        bus_write(A_IE, 8'h01);
        bus_write(A_MODE, 8'h01);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick();
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL edge_req_early: got %b expected 0 at cycle 3", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL edge_req_cycle4: got %b expected 1", irq_req); end
        checks++; if (irq_vector !== 16'h0002) begin errors++; $display("FAIL edge_vector: got %h expected 0002", irq_vector); end
        do_ack();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL edge_req_after_ack: got %b expected 0", irq_req); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL edge_isr: got %h expected 01", rd); end
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL edge_active: got %b expected 1", irq_active); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL edge_pend_cleared: got %h expected 00", rd); end
        bus_write(A_EOI, 8'h00);
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL edge_eoi_isr: got %h expected 00", rd); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL edge_eoi_active: got %b expected 0", irq_active); end
    endtask

    task automatic test_priority_nesting();
        bus_write(A_IE, 8'hFF);
        bus_write(A_MODE, 8'hFF);
        pulse_irq(3);
        wait_req(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_ch3_req: got timeout expected request"); end
        checks++; if (irq_vector !== 16'h0008) begin errors++; $display("FAIL prio_ch3_vector: got %h expected 0008", irq_vector); end
        do_ack();
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL prio_isr_08: got %h expected 08", rd); end
        pulse_irq(5);
        repeat (6) tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_ch5_blocked: got %b expected 0", irq_req); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h20) begin errors++; $display("FAIL prio_pend_20: got %h expected 20", rd); end
        pulse_irq(1);
        wait_req(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_ch1_req: got timeout expected request"); end
        checks++; if (irq_vector !== 16'h0004) begin errors++; $display("FAIL prio_ch1_vector: got %h expected 0004", irq_vector); end
        do_ack();
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h0A) begin errors++; $display("FAIL prio_isr_0a: got %h expected 0a", rd); end
        bus_write(A_EOI, 8'h00);
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL prio_eoi1_isr: got %h expected 08", rd); end
        repeat (4) tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_ch5_still_blocked: got %b expected 0", irq_req); end
        bus_write(A_EOI, 8'h00);
        wait_req(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_ch5_req: got timeout expected request"); end
        checks++; if (irq_vector !== 16'h000C) begin errors++; $display("FAIL prio_ch5_vector: got %h expected 000c", irq_vector); end
        do_ack();
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h20) begin errors++; $display("FAIL prio_isr_20: got %h expected 20", rd); end
        bus_write(A_EOI, 8'h00);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL prio_pend_final: got %h expected 00", rd); end
    endtask

    task automatic test_level();
        bus_write(A_MODE, 8'h00);
        bus_write(A_IE, 8'h04);
        irq_in[2] = 1'b1;
        wait_req(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL level_req: got timeout expected request"); end
        checks++; if (irq_vector !== 16'h0006) begin errors++; $display("FAIL level_vector: got %h expected 0006", irq_vector); end
        do_ack();
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h04) begin errors++; $display("FAIL level_isr: got %h expected 04", rd); end
        repeat (3) tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL level_blocked_by_isr: got %b expected 0", irq_req); end
        bus_write(A_EOI, 8'h00);
        wait_req(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL level_reassert: got timeout expected request"); end
        irq_in[2] = 1'b0;
        repeat (3) tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL level_drop_early: got %b expected 1", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL level_drop_withdraw: got %b expected 0", irq_req); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL level_pend: got %h expected 00", rd); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL level_isr_final: got %h expected 00", rd); end
    endtask

    task automatic test_withdrawal();
        bus_write(A_MODE, 8'h10);
        bus_write(A_IE, 8'h10);
        pulse_irq(4);
        wait_req(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wd_req: got timeout expected request"); end
        checks++; if (irq_vector !== 16'h000A) begin errors++; $display("FAIL wd_vector: got %h expected 000a", irq_vector); end
        bus_write(A_IE, 8'h00);
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL wd_req_same_cycle: got %b expected 1", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_req_next_cycle: got %b expected 0", irq_req); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wd_isr: got %h expected 00", rd); end
        do_ack();
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL stray_ack_req: got %b expected 0", irq_req); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL stray_ack_isr: got %h expected 00", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("FAIL stray_ack_pend: got %h expected 10", rd); end
        bus_write(A_PEND, 8'h10);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL w1c_pend: got %h expected 00", rd); end
    endtask

    task automatic test_corners();
        bus_write(A_SWI, 8'h10);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("FAIL swi_pend: got %h expected 10", rd); end
        // Pin rise at n0 sets PEND on edge 3; the W1C below lands on that same edge.
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        tick();
        bus_write(A_PEND, 8'h10);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("FAIL w1c_vs_edge: got %h expected 10", rd); end
        bus_write(A_PEND, 8'h10);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL w1c_after_edge: got %h expected 00", rd); end
        bus_write(A_SWI, 8'h01);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL swi_level_ignored: got %h expected 00", rd); end
        bus_write(A_EOI, 8'hFF);
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL eoi_empty: got %h expected 00", rd); end
        bus_write(A_RSV6, 8'hFF);
        bus_read(A_RSV6, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rsv6_read: got %h expected 00", rd); end
        bus_read(A_IE, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rsv6_no_side_effect: got %h expected 00", rd); end
        bus_read(A_MODE, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("FAIL mode_readback: got %h expected 10", rd); end
        bus_read(A_OUT, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL out_of_window: got %h expected 00", rd); end
    endtask

    task automatic test_reset_mid();
        bus_write(A_IE, 8'h03);
        bus_write(A_MODE, 8'h03);
        pulse_irq(1);
        wait_req(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_ch1_req: got timeout expected request"); end
        do_ack();
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL rm_isr: got %h expected 02", rd); end
        pulse_irq(0);
        wait_req(8, ok);
        checks++; if (!ok || irq_vector !== 16'h0002) begin errors++; $display("FAIL rm_ch0_req: got req=%b vec=%h expected req=1 vec=0002", irq_req, irq_vector); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rm_async_req: got %b expected 0", irq_req); end
        checks++; if (irq_vector !== 16'h0000) begin errors++; $display("FAIL rm_async_vector: got %h expected 0000", irq_vector); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL rm_async_active: got %b expected 0", irq_active); end
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rm_async_rdata: got %h expected 00", bus_rdata); end
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(A_IE, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rm_ie: got %h expected 00", rd); end
        bus_read(A_ISR, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rm_isr_cleared: got %h expected 00", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rm_pend_cleared: got %h expected 00", rd); end
        pulse_irq(0);
        repeat (6) tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rm_no_req: got %b expected 0", irq_req); end
    endtask

    initial begin
        irq_in    = 8'h00;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        irq_ack   = 1'b0;
        test_reset();
        test_edge_single();
        test_priority_nesting();
        test_level();
        test_withdrawal();
        test_corners();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
